dram_ls_unit: RTL and testbench

Data-RAM responder for the load/store path. Accepts one request per transaction using the decoder's `memread`/`memwrite`/`mask` encoding, performs byte-lane alignment, and splits misaligned accesses into two word accesses. It drives a word-wide synchronous RAM and returns sign- or zero-extended load data. It sits between the MEM-stage request and the data RAM.

---
 rtl/dram_ls_unit.sv | 168 ++++++++++++++++
 tb/tb_dram_ls_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_ls_unit.sv
// Data-RAM load/store responder: aligns byte lanes, splits misaligned accesses
// into two word accesses, and returns sign/zero-extended load data.
module dram_ls_unit #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [2:0]        mask,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_ACC0, S_ACC1, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic        r_rd;
  logic        r_sext;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic        r_split;
  logic [3:0]  r_hi_we;
  logic [31:0] r_hi_wdata;
  logic [31:0] r_lo;

  logic        w_illegal;
  logic [1:0]  w_off;
  logic [3:0]  w_base;
  logic [7:0]  w_en8;
  logic [63:0] w_span;
  logic        w_split;
  logic [63:0] w_pair;
  logic [63:0] w_shift;
  logic [31:0] w_ext;
  logic        w_unused;

  // Request-side lane alignment, evaluated on the inputs at acceptance
  assign w_illegal = (mask[1:0] == 2'b11) || (memread == memwrite);
  assign w_off     = addr[1:0];
  assign w_split   = ((mask[1:0] == 2'b10) && (w_off != 2'b00)) ||
                     ((mask[1:0] == 2'b01) && (w_off == 2'b11));
  assign w_en8     = {4'b0000, w_base} << w_off;
  assign w_span    = {32'b0, wdata} << {w_off, 3'b000};
  assign w_unused  = &{1'b0, addr[31:ADDR_W+2]};

  always_comb begin
    w_base = 4'b1111;
    case (mask[1:0])
      2'b00:   w_base = 4'b0001;
      2'b01:   w_base = 4'b0011;
      default: w_base = 4'b1111;
    endcase
  end

  // Load-side merge of the captured word(s), then size select and extension
  assign w_pair  = r_split ? {ram_rdata, r_lo} : {32'b0, ram_rdata};
  assign w_shift = w_pair >> {r_off, 3'b000};

  always_comb begin
    w_ext = w_shift[31:0];
    case (r_size)
      2'b00:   w_ext = {{24{r_sext & w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_ext = {{16{r_sext & w_shift[15]}}, w_shift[15:0]};
      default: w_ext = w_shift[31:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rdata      <= 32'h0;
      ram_en     <= 1'b0;
      ram_we     <= 4'h0;
      ram_addr   <= '0;
      ram_wdata  <= 32'h0;
      r_rd       <= 1'b0;
      r_sext     <= 1'b0;
      r_size     <= 2'b00;
      r_off      <= 2'b00;
      r_split    <= 1'b0;
      r_hi_we    <= 4'h0;
      r_hi_wdata <= 32'h0;
      r_lo       <= 32'h0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 4'h0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            rdata      <= 32'h0;
            r_rd       <= memread;
            r_sext     <= mask[2];
            r_size     <= mask[1:0];
            r_off      <= w_off;
            r_split    <= w_split;
            r_hi_we    <= memwrite ? w_en8[7:4] : 4'h0;
            r_hi_wdata <= w_span[63:32];
            if (w_illegal) begin
              r_state   <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              r_state   <= S_ACC0;
              ram_en    <= 1'b1;
              ram_addr  <= addr[ADDR_W+1:2];
              ram_we    <= memwrite ? w_en8[3:0] : 4'h0;
              ram_wdata <= w_span[31:0];
            end
          end
        end
        S_ACC0: begin
          if (r_split) begin
            r_state   <= S_ACC1;
            ram_en    <= 1'b1;
            ram_addr  <= ram_addr + ADDR_W'(1);
            ram_we    <= r_hi_we;
            ram_wdata <= r_hi_wdata;
          end else if (r_rd) begin
            r_state <= S_WAIT;
          end else begin
            r_state   <= S_RESP;
            rsp_valid <= 1'b1;
          end
        end
        S_ACC1: begin
          if (r_rd) begin
            r_lo    <= ram_rdata;
            r_state <= S_WAIT;
          end else begin
            r_state   <= S_RESP;
            rsp_valid <= 1'b1;
          end
        end
        S_WAIT: begin
          rdata     <= w_ext;
          r_state   <= S_RESP;
          rsp_valid <= 1'b1;
        end
        S_RESP: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_ls_unit.sv
// Scoreboard bench for dram_ls_unit with a behavioural synchronous word RAM.
module tb_dram_ls_unit;

  localparam int unsigned ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              memread;
  logic              memwrite;
  logic [2:0]        mask;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [31:0]       rdata;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  logic [31:0] mem [1024];

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  typedef struct {
    logic        rd;
    logic [2:0]  m;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
    int          lat;
    logic        split;
    logic [9:0]  a0;
    logic [3:0]  we0;
    logic [31:0] wd0;
    logic [9:0]  a1;
    logic [3:0]  we1;
    logic [31:0] wd1;
  } txn_t;

  rsp_t exp_q[$];

  dram_ls_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .memread(memread), .memwrite(memwrite), .mask(mask), .addr(addr), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rdata(rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after the enable
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
  end

  // Drives one request for a single cycle, then scrambles the request inputs
  task automatic drive_req(input logic rd, input logic wr, input logic [2:0] m,
                           input logic [31:0] a, input logic [31:0] wd);
    memread = rd; memwrite = wr; mask = m; addr = a; wdata = wd; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; memread = ~rd; memwrite = ~wr;
    mask = 3'($urandom); addr = $urandom; wdata = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
    mask = 3'b000; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_err, rdata, ram_en, ram_we, ram_addr, ram_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b e=%b rd=%h en=%b we=%b a=%h wd=%h required all zero",
               rsp_valid, rsp_err, rdata, ram_en, ram_we, ram_addr, ram_wdata);
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got %b required 1", req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_aligned();
    txn_t tq[$];
    rsp_t e;
    int   cyc;
    tq.push_back('{1'b0, 3'b010, 32'h10, 32'h8899AABB, 32'h0,        2, 1'b0, 10'h4, 4'hF, 32'h8899AABB, 10'h0, 4'h0, 32'h0});
    tq.push_back('{1'b1, 3'b100, 32'h12, 32'h0,        32'hFFFFFF99, 3, 1'b0, 10'h4, 4'h0, 32'h0,        10'h0, 4'h0, 32'h0});
    tq.push_back('{1'b1, 3'b000, 32'h12, 32'h0,        32'h00000099, 3, 1'b0, 10'h4, 4'h0, 32'h0,        10'h0, 4'h0, 32'h0});
    tq.push_back('{1'b1, 3'b101, 32'h12, 32'h0,        32'hFFFF8899, 3, 1'b0, 10'h4, 4'h0, 32'h0,        10'h0, 4'h0, 32'h0});
    tq.push_back('{1'b1, 3'b010, 32'h10, 32'h0,        32'h8899AABB, 3, 1'b0, 10'h4, 4'h0, 32'h0,        10'h0, 4'h0, 32'h0});
    tq.push_back('{1'b0, 3'b100, 32'h13, 32'h1234567F, 32'h0,        2, 1'b0, 10'h4, 4'h8, 32'h7F000000, 10'h0, 4'h0, 32'h0});
    tq.push_back('{1'b1, 3'b100, 32'h13, 32'h0,        32'h0000007F, 3, 1'b0, 10'h4, 4'h0, 32'h0,        10'h0, 4'h0, 32'h0});
    tq.push_back('{1'b1, 3'b101, 32'h10, 32'h0,        32'hFFFFAABB, 3, 1'b0, 10'h4, 4'h0, 32'h0,        10'h0, 4'h0, 32'h0});
    foreach (tq[i]) begin
      exp_q.push_back('{1'b0, tq[i].exp});
      drive_req(tq[i].rd, ~tq[i].rd, tq[i].m, tq[i].a, tq[i].wd);
      n_cmp++;
      if ({ram_en, ram_addr, ram_we, req_ready} !== {1'b1, tq[i].a0, tq[i].we0, 1'b0}) begin
        n_fail++;
        $display("FAIL aligned_acc0[%0d] got en=%b a=%h we=%b rdy=%b required 1/%h/%b/0",
                 i, ram_en, ram_addr, ram_we, req_ready, tq[i].a0, tq[i].we0);
      end
      if (!tq[i].rd) begin
        n_cmp++;
        if (ram_wdata !== tq[i].wd0) begin
          n_fail++; $display("FAIL aligned_wdata[%0d] got %h required %h", i, ram_wdata, tq[i].wd0);
        end
      end
      cyc = 1;
      while (rsp_valid !== 1'b1 && cyc < 12) begin @(negedge clk); cyc++; end
      e = exp_q.pop_front();
      n_cmp++;
      if (rsp_valid !== 1'b1 || cyc != tq[i].lat) begin
        n_fail++; $display("FAIL aligned_latency[%0d] got %0d required %0d", i, cyc, tq[i].lat);
      end
      n_cmp++;
      if ({rsp_err, rdata} !== {e.err, e.rdata}) begin
        n_fail++;
        $display("FAIL aligned_rsp[%0d] got err=%b rdata=%h required err=%b rdata=%h",
                 i, rsp_err, rdata, e.err, e.rdata);
      end
      @(negedge clk);
      n_cmp++;
      if ({req_ready, rsp_valid} !== 2'b10) begin
        n_fail++; $display("FAIL aligned_idle[%0d] got rdy=%b v=%b required 1/0", i, req_ready, rsp_valid);
      end
    end
  endtask

  task automatic test_split();
    txn_t tq[$];
    rsp_t e;
    int   cyc;
    tq.push_back('{1'b0, 3'b110, 32'h21,   32'h11223344, 32'h0,        3, 1'b1, 10'h8,   4'hE, 32'h22334400, 10'h9, 4'h1, 32'h00000011});
    tq.push_back('{1'b1, 3'b010, 32'h21,   32'h0,        32'h11223344, 4, 1'b1, 10'h8,   4'h0, 32'h0,        10'h9, 4'h0, 32'h0});
    tq.push_back('{1'b0, 3'b010, 32'h20,   32'hAA000000, 32'h0,        2, 1'b0, 10'h8,   4'hF, 32'hAA000000, 10'h0, 4'h0, 32'h0});
    tq.push_back('{1'b0, 3'b010, 32'h24,   32'h000000F1, 32'h0,        2, 1'b0, 10'h9,   4'hF, 32'h000000F1, 10'h0, 4'h0, 32'h0});
    tq.push_back('{1'b1, 3'b101, 32'h23,   32'h0,        32'hFFFFF1AA, 4, 1'b1, 10'h8,   4'h0, 32'h0,        10'h9, 4'h0, 32'h0});
    tq.push_back('{1'b1, 3'b001, 32'h23,   32'h0,        32'h0000F1AA, 4, 1'b1, 10'h8,   4'h0, 32'h0,        10'h9, 4'h0, 32'h0});
    tq.push_back('{1'b0, 3'b010, 32'hFFC,  32'hCAFEF00D, 32'h0,        2, 1'b0, 10'h3FF, 4'hF, 32'hCAFEF00D, 10'h0, 4'h0, 32'h0});
    tq.push_back('{1'b0, 3'b010, 32'h0,    32'h12345678, 32'h0,        2, 1'b0, 10'h0,   4'hF, 32'h12345678, 10'h0, 4'h0, 32'h0});
    tq.push_back('{1'b1, 3'b010, 32'h1FFE, 32'h0,        32'h5678CAFE, 4, 1'b1, 10'h3FF, 4'h0, 32'h0,        10'h0, 4'h0, 32'h0});
    tq.push_back('{1'b0, 3'b001, 32'hFFF,  32'h0000BEEF, 32'h0,        3, 1'b1, 10'h3FF, 4'h8, 32'hEF000000, 10'h0, 4'h1, 32'h000000BE});
    tq.push_back('{1'b1, 3'b010, 32'hFFC,  32'h0,        32'hEFFEF00D, 3, 1'b0, 10'h3FF, 4'h0, 32'h0,        10'h0, 4'h0, 32'h0});
    tq.push_back('{1'b1, 3'b010, 32'h0,    32'h0,        32'h123456BE, 3, 1'b0, 10'h0,   4'h0, 32'h0,        10'h0, 4'h0, 32'h0});
    foreach (tq[i]) begin
      exp_q.push_back('{1'b0, tq[i].exp});
      drive_req(tq[i].rd, ~tq[i].rd, tq[i].m, tq[i].a, tq[i].wd);
      n_cmp++;
      if ({ram_en, ram_addr, ram_we} !== {1'b1, tq[i].a0, tq[i].we0} ||
          (!tq[i].rd && ram_wdata !== tq[i].wd0)) begin
        n_fail++;
        $display("FAIL split_acc0[%0d] got en=%b a=%h we=%b wd=%h required 1/%h/%b/%h",
                 i, ram_en, ram_addr, ram_we, ram_wdata, tq[i].a0, tq[i].we0, tq[i].wd0);
      end
      cyc = 1;
      if (tq[i].split) begin
        @(negedge clk); cyc++;
        n_cmp++;
        if ({ram_en, ram_addr, ram_we} !== {1'b1, tq[i].a1, tq[i].we1} ||
            (!tq[i].rd && ram_wdata !== tq[i].wd1)) begin
          n_fail++;
          $display("FAIL split_acc1[%0d] got en=%b a=%h we=%b wd=%h required 1/%h/%b/%h",
                   i, ram_en, ram_addr, ram_we, ram_wdata, tq[i].a1, tq[i].we1, tq[i].wd1);
        end
      end
      while (rsp_valid !== 1'b1 && cyc < 12) begin @(negedge clk); cyc++; end
      e = exp_q.pop_front();
      n_cmp++;
      if (rsp_valid !== 1'b1 || cyc != tq[i].lat) begin
        n_fail++; $display("FAIL split_latency[%0d] got %0d required %0d", i, cyc, tq[i].lat);
      end
      n_cmp++;
      if ({rsp_err, rdata} !== {e.err, e.rdata}) begin
        n_fail++;
        $display("FAIL split_rsp[%0d] got err=%b rdata=%h required err=%b rdata=%h",
                 i, rsp_err, rdata, e.err, e.rdata);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_error();
    logic [4:0] cases [3];
    rsp_t e;
    logic saw_en;
    cases[0] = {1'b1, 1'b0, 3'b111};
    cases[1] = {1'b1, 1'b1, 3'b010};
    cases[2] = {1'b0, 1'b0, 3'b000};
    foreach (cases[i]) begin
      exp_q.push_back('{1'b1, 32'h0});
      drive_req(cases[i][4], cases[i][3], cases[i][2:0], 32'h10, 32'h55AA55AA);
      e = exp_q.pop_front();
      saw_en = ram_en;
      n_cmp++;
      if ({rsp_valid, rsp_err, rdata} !== {1'b1, e.err, e.rdata}) begin
        n_fail++;
        $display("FAIL error_rsp[%0d] got v=%b err=%b rdata=%h required 1/%b/%h",
                 i, rsp_valid, rsp_err, rdata, e.err, e.rdata);
      end
      repeat (3) begin @(negedge clk); saw_en |= ram_en; end
      n_cmp++;
      if (saw_en !== 1'b0 || req_ready !== 1'b1) begin
        n_fail++; $display("FAIL error_noaccess[%0d] got en_seen=%b rdy=%b required 0/1", i, saw_en, req_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    rsp_t e;
    int   cyc;
    logic saw_we;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back('{1'b0, 32'h7F99AABB});
      drive_req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
      saw_we = |ram_we;
      // A store presented while busy must be dropped
      memread = 1'b0; memwrite = 1'b1; mask = 3'b010; addr = 32'h10; wdata = 32'hDEADBEEF;
      req_valid = (k == 0);
      cyc = 1;
      while (rsp_valid !== 1'b1 && cyc < 12) begin
        @(negedge clk); cyc++; saw_we |= (ram_en & |ram_we);
        if (cyc == 3) req_valid = 1'b0;
      end
      req_valid = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if (rsp_valid !== 1'b1 || cyc != 3 || saw_we !== 1'b0) begin
        n_fail++; $display("FAIL busy_latency[%0d] got %0d we_seen=%b required 3/0", k, cyc, saw_we);
      end
      n_cmp++;
      if ({rsp_err, rdata} !== {e.err, e.rdata}) begin
        n_fail++; $display("FAIL busy_rsp[%0d] got rdata=%h required %h", k, rdata, e.rdata);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_abort();
    rsp_t e;
    int   cyc;
    logic saw;
    drive_req(1'b1, 1'b0, 3'b101, 32'h23, 32'h0);
    @(negedge clk);
    n_cmp++;
    if ({ram_en, ram_addr} !== {1'b1, 10'h9}) begin
      n_fail++; $display("FAIL abort_acc1 got en=%b a=%h required 1/009", ram_en, ram_addr);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({rsp_valid, rdata, ram_en, ram_we, ram_addr, ram_wdata, req_ready} !== {1'b0, 32'h0, 1'b0, 4'h0, 10'h0, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_outputs got v=%b rd=%h en=%b we=%b a=%h wd=%h rdy=%b required zeros/rdy=1",
               rsp_valid, rdata, ram_en, ram_we, ram_addr, ram_wdata, req_ready);
    end
    saw = 1'b0;
    repeat (3) begin @(negedge clk); saw |= rsp_valid | ram_en; end
    rst = 1'b0;
    repeat (2) begin @(negedge clk); saw |= rsp_valid | ram_en; end
    n_cmp++;
    if (saw !== 1'b0) begin
      n_fail++; $display("FAIL abort_quiet got activity=%b required 0", saw);
    end
    exp_q.push_back('{1'b0, 32'h00000099});
    drive_req(1'b1, 1'b0, 3'b000, 32'h12, 32'h0);
    cyc = 1;
    while (rsp_valid !== 1'b1 && cyc < 12) begin @(negedge clk); cyc++; end
    e = exp_q.pop_front();
    n_cmp++;
    if (rsp_valid !== 1'b1 || cyc != 3 || {rsp_err, rdata} !== {e.err, e.rdata}) begin
      n_fail++;
      $display("FAIL abort_followup got lat=%0d err=%b rdata=%h required 3/%b/%h", cyc, rsp_err, rdata, e.err, e.rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_split();
    test_error();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
